// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE control slice: control register indices
// (address bits [5:3]) and the arbiter state encoding.
package hwpe_ctrl_package;

  localparam logic [2:0] REG_TRIGGER = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_JOBID   = 3'd2;
  localparam logic [2:0] REG_SOFTCLR = 3'd3;
  localparam logic [2:0] REG_PUSH    = 3'd4;
  localparam logic [2:0] REG_PULL    = 3'd5;

  typedef enum logic [0:0] {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_RSP = 1'b1
  } arb_state_e;

  // Reads of STATUS and JOBID never disturb a job being programmed, so any
  // requester may issue them even while another one owns the engine.
  function automatic logic is_shared_read(input logic write, input logic [2:0] reg_idx);
    return !write && ((reg_idx == REG_STATUS) || (reg_idx == REG_JOBID));
  endfunction

endpackage

// File: rtl/hwpe_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from an internal
// priority pointer; the pointer advances past the grantee on acceptance.
module hwpe_ctrl_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from the pointer with wrap-around and grant the first requester seen.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // Move the pointer past the accepted grantee so it drops to lowest priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (advance) begin
      rr_q <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/hwpe_ctrl_reqrsp_arbiter.sv
// Shares one HWPE reqrsp configuration port between N_REQ requesters with
// one transaction in flight, response routing back to the issuer, and an
// ownership lock that keeps a job's programming sequence uninterrupted.
module hwpe_ctrl_reqrsp_arbiter
  import hwpe_ctrl_package::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [N_REQ-1:0]                        req_q_valid_i,
  input  logic [N_REQ-1:0]                        req_q_write_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        req_q_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]        req_q_data_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]      req_q_strb_i,
  output logic [N_REQ-1:0]                        req_q_ready_o,
  output logic [N_REQ-1:0]                        req_p_valid_o,
  output logic [N_REQ-1:0][DATA_WIDTH-1:0]        req_p_data_o,
  input  logic [N_REQ-1:0]                        req_p_ready_i,
  output logic                                    tgt_q_valid_o,
  output logic                                    tgt_q_write_o,
  output logic [ADDR_WIDTH-1:0]                   tgt_q_addr_o,
  output logic [DATA_WIDTH-1:0]                   tgt_q_data_o,
  output logic [DATA_WIDTH/8-1:0]                 tgt_q_strb_o,
  input  logic                                    tgt_q_ready_i,
  input  logic                                    tgt_p_valid_i,
  input  logic [DATA_WIDTH-1:0]                   tgt_p_data_i,
  output logic                                    tgt_p_ready_o,
  output logic                                    lock_valid_o,
  output logic [$clog2(N_REQ)-1:0]                lock_owner_o
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_owner_q, lock_owner_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             accept;
  logic             gnt_write;
  logic [2:0]       gnt_reg;

  // While locked, non-owners may only read STATUS/JOBID; everything else waits.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_q_valid_i[i] &&
                    (!lock_q || (lock_owner_q == IDX_W'(i)) ||
                     is_shared_read(req_q_write_i[i], req_q_addr_i[i][5:3]));
    end
  end

  assign arb_req = (state_q == ARB_IDLE) ? eligible : '0;

  hwpe_ctrl_rr_arb #(
    .N (N_REQ)
  ) i_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (arb_req),
    .advance (accept),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign tgt_q_valid_o = |arb_req;
  assign tgt_q_write_o = req_q_write_i[gnt_idx];
  assign tgt_q_addr_o  = req_q_addr_i[gnt_idx];
  assign tgt_q_data_o  = req_q_data_i[gnt_idx];
  assign tgt_q_strb_o  = req_q_strb_i[gnt_idx];
  assign req_q_ready_o = gnt & {N_REQ{tgt_q_ready_i}};
  assign accept        = tgt_q_valid_o & tgt_q_ready_i;
  assign gnt_write     = req_q_write_i[gnt_idx];
  assign gnt_reg       = req_q_addr_i[gnt_idx][5:3];

  assign lock_valid_o  = lock_q;
  assign lock_owner_o  = lock_owner_q;

  // Route the target response to the issuer; drain stray responses otherwise.
  always_comb begin
    req_p_valid_o = '0;
    req_p_data_o  = '0;
    tgt_p_ready_o = 1'b1;
    if (state_q == ARB_WAIT_RSP) begin
      req_p_valid_o[owner_q] = tgt_p_valid_i;
      req_p_data_o[owner_q]  = tgt_p_data_i;
      tgt_p_ready_o          = req_p_ready_i[owner_q];
    end
  end

  // Next state, response owner and lock; all updates happen on acceptance.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d = ARB_WAIT_RSP;
          owner_d = gnt_idx;
          if (gnt_write) begin
            if (gnt_reg == REG_SOFTCLR) begin
              lock_d = 1'b0;
            end else if ((gnt_reg == REG_TRIGGER) && lock_q && (gnt_idx == lock_owner_q)) begin
              lock_d = 1'b0;
            end else if ((gnt_reg == REG_PUSH) && !lock_q) begin
              lock_d       = 1'b1;
              lock_owner_d = gnt_idx;
            end
          end
        end
      end
      ARB_WAIT_RSP: begin
        if (tgt_p_valid_i && tgt_p_ready_o) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, response owner and lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_arbiter.sv
// Bench for hwpe_ctrl_reqrsp_arbiter: a table of single-requester lock
// vectors plus hand sequences, with a response scoreboard and target model.
module tb_hwpe_ctrl_reqrsp_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  localparam logic [2:0] R_TRIG = 3'd0;
  localparam logic [2:0] R_STAT = 3'd1;
  localparam logic [2:0] R_JOB  = 3'd2;
  localparam logic [2:0] R_SCLR = 3'd3;
  localparam logic [2:0] R_PUSH = 3'd4;
  localparam logic [2:0] R_PULL = 3'd5;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           req_q_valid_i, req_q_write_i, req_q_ready_o;
  logic [N-1:0][AW-1:0]   req_q_addr_i;
  logic [N-1:0][DW-1:0]   req_q_data_i;
  logic [N-1:0][SW-1:0]   req_q_strb_i;
  logic [N-1:0]           req_p_valid_o, req_p_ready_i;
  logic [N-1:0][DW-1:0]   req_p_data_o;
  logic                   tgt_q_valid_o, tgt_q_write_o, tgt_q_ready_i;
  logic [AW-1:0]          tgt_q_addr_o;
  logic [DW-1:0]          tgt_q_data_o;
  logic [SW-1:0]          tgt_q_strb_o;
  logic                   tgt_p_valid_i, tgt_p_ready_o;
  logic [DW-1:0]          tgt_p_data_i;
  logic                   lock_valid_o;
  logic [1:0]             lock_owner_o;

  typedef struct { int idx; logic [DW-1:0] data; } sb_t;
  typedef struct { int req; bit wr; logic [2:0] r; logic [DW-1:0] d; int gnt; bit lock; int owner; } vec_t;

  sb_t  sb[$];
  vec_t tbl [19];
  int   n_vec = 0;
  int   n_err = 0;
  int   rr_exp = 0;

  logic                 tgt_pend;
  logic [DW-1:0]        tgt_rsp;
  logic [N-1:0][DW-1:0] expv;
  logic [N-1:0][DW-1:0] mon_exp;
  sb_t                  mon_e;

  always #5 clk = ~clk;

  hwpe_ctrl_reqrsp_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_q_valid_i(req_q_valid_i), .req_q_write_i(req_q_write_i), .req_q_addr_i(req_q_addr_i),
    .req_q_data_i(req_q_data_i), .req_q_strb_i(req_q_strb_i), .req_q_ready_o(req_q_ready_o),
    .req_p_valid_o(req_p_valid_o), .req_p_data_o(req_p_data_o), .req_p_ready_i(req_p_ready_i),
    .tgt_q_valid_o(tgt_q_valid_o), .tgt_q_write_o(tgt_q_write_o), .tgt_q_addr_o(tgt_q_addr_o),
    .tgt_q_data_o(tgt_q_data_o), .tgt_q_strb_o(tgt_q_strb_o), .tgt_q_ready_i(tgt_q_ready_i),
    .tgt_p_valid_i(tgt_p_valid_i), .tgt_p_data_i(tgt_p_data_i), .tgt_p_ready_o(tgt_p_ready_o),
    .lock_valid_o(lock_valid_o), .lock_owner_o(lock_owner_o)
  );

  // Target response contents: STATUS reads 1, other reads echo the address, writes invert data.
  function automatic logic [DW-1:0] rsp_of(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w) return ~d;
    if (a[5:3] == R_STAT) return 64'h1;
    return {32'hBEEF_0000, a};
  endfunction

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Target model: responds in the cycle after acceptance, holds until handshake.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_pend <= 1'b0;
      tgt_rsp  <= '0;
    end else if (tgt_q_valid_o && tgt_q_ready_i) begin
      tgt_pend <= 1'b1;
      tgt_rsp  <= rsp_of(tgt_q_write_o, tgt_q_addr_o, tgt_q_data_o);
    end else if (tgt_p_valid_i && tgt_p_ready_o) begin
      tgt_pend <= 1'b0;
    end
  end
  assign tgt_p_valid_i = tgt_pend;
  assign tgt_p_data_i  = tgt_rsp;

  // Response monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int i = 0; i < N; i++) begin
        if (req_p_valid_o[i] && req_p_ready_i[i]) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: requester %0d got %0h, expected no response", i, req_p_data_o[i]);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_idx", i, mon_e.idx);
            mon_exp = '0;
            mon_exp[mon_e.idx] = mon_e.data;
            check("rsp_data", req_p_data_o, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input int i, input bit wr, input logic [2:0] r, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_q_valid_i[i] = 1'b1;
    req_q_write_i[i] = wr;
    req_q_addr_i[i]  = 32'h1000_0000 | (32'(i) << 8) | (32'(r) << 3);
    req_q_data_i[i]  = d;
    req_q_strb_i[i]  = s;
  endtask

  task automatic clear_reqs();
    req_q_valid_i = '0;
    req_q_write_i = '0;
  endtask

  // Check the grant of the current IDLE cycle, then step to the next cycle.
  task automatic step_check(input string name, input int g);
    logic [N-1:0] rdy;
    #3;
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    check({name, " q_ready"}, req_q_ready_o, rdy);
    check({name, " tgt_q_valid"}, tgt_q_valid_o, (g >= 0));
    if (g >= 0) begin
      check({name, " tgt_addr"}, tgt_q_addr_o, req_q_addr_i[g]);
      check({name, " tgt_wdata"}, {tgt_q_write_o, tgt_q_strb_o, tgt_q_data_o},
            {req_q_write_i[g], req_q_strb_i[g], req_q_data_i[g]});
      sb.push_back('{g, rsp_of(req_q_write_i[g], req_q_addr_i[g], req_q_data_i[g])});
      rr_exp = (g + 1) % N;
    end
    @(posedge clk); #1;
  endtask

  // Response cycle: nothing forwarded, exactly one response presented.
  task automatic rsp_cycle(input string name);
    #3;
    check({name, " wait q_ready"}, req_q_ready_o, 0);
    check({name, " wait tgt_q_valid"}, tgt_q_valid_o, 0);
    check({name, " p_valid count"}, $countones(req_p_valid_o), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1, 1'b1, R_PUSH, 64'hA5, 1, 1'b1, 1};
    tbl[1]  = '{0, 1'b1, R_PUSH, 64'h11, -1, 1'b1, 1};
    tbl[2]  = '{0, 1'b0, R_STAT, 64'h0, 0, 1'b1, 1};
    tbl[3]  = '{2, 1'b0, R_JOB, 64'h0, 2, 1'b1, 1};
    tbl[4]  = '{3, 1'b1, R_TRIG, 64'h33, -1, 1'b1, 1};
    tbl[5]  = '{3, 1'b0, R_PULL, 64'h0, -1, 1'b1, 1};
    tbl[6]  = '{1, 1'b0, R_PULL, 64'h0, 1, 1'b1, 1};
    tbl[7]  = '{1, 1'b1, R_PULL, 64'h77, 1, 1'b1, 1};
    tbl[8]  = '{1, 1'b1, R_PUSH, 64'h88, 1, 1'b1, 1};
    tbl[9]  = '{2, 1'b1, R_STAT, 64'h99, -1, 1'b1, 1};
    tbl[10] = '{1, 1'b1, R_TRIG, 64'h1, 1, 1'b0, 0};
    tbl[11] = '{0, 1'b1, R_PUSH, 64'h5A, 0, 1'b1, 0};
    tbl[12] = '{2, 1'b1, R_SCLR, 64'h2, -1, 1'b1, 0};
    tbl[13] = '{0, 1'b1, R_SCLR, 64'h3, 0, 1'b0, 0};
    tbl[14] = '{3, 1'b1, R_SCLR, 64'h4, 3, 1'b0, 0};
    tbl[15] = '{2, 1'b1, R_TRIG, 64'h5, 2, 1'b0, 0};
    tbl[16] = '{2, 1'b0, R_STAT, 64'h0, 2, 1'b0, 0};
    tbl[17] = '{3, 1'b1, R_PUSH, 64'hC3, 3, 1'b1, 3};
    tbl[18] = '{3, 1'b1, R_SCLR, 64'h6, 3, 1'b0, 0};

    rst_ni = 1'b0;
    clear_reqs();
    req_q_addr_i  = '0;
    req_q_data_i  = '0;
    req_q_strb_i  = '0;
    req_p_ready_i = '1;
    tgt_q_ready_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst q_ready", req_q_ready_o, 0);
    check("rst p_valid", req_p_valid_o, 0);
    check("rst tgt_q_valid", tgt_q_valid_o, 0);
    check("rst tgt_p_ready", tgt_p_ready_o, 1);
    check("rst lock", {lock_valid_o, lock_owner_o}, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Requester 2 reads STATUS, first with the target stalling.
    tgt_q_ready_i = 1'b0;
    drive(2, 1'b0, R_STAT, 64'h0, 8'h00);
    #3;
    check("stall tgt_q_valid", tgt_q_valid_o, 1);
    check("stall q_ready", req_q_ready_o, 0);
    check("stall reg idx", tgt_q_addr_o[5:3], 1);
    @(posedge clk); #1;
    tgt_q_ready_i = 1'b1;
    step_check("status", 2);
    clear_reqs();
    #3;
    expv = '0;
    expv[2] = 64'h1;
    check("status p_valid", req_p_valid_o, 4'b0100);
    check("status p_data", req_p_data_o, expv);
    @(posedge clk); #1;

    // All four read JOBID continuously: grants rotate starting at the pointer.
    for (int i = 0; i < N; i++) drive(i, 1'b0, R_JOB, 64'(i), 8'hFF);
    for (int t = 0; t < 5; t++) begin
      step_check($sformatf("rr%0d", t), rr_exp);
      rsp_cycle($sformatf("rr%0d", t));
    end
    clear_reqs();

    // Single-requester lock vectors.
    for (int v = 0; v < 19; v++) begin
      clear_reqs();
      drive(tbl[v].req, tbl[v].wr, tbl[v].r, tbl[v].d ^ (64'(v) << 32), SW'(8'hF0 ^ 8'(v)));
      step_check($sformatf("vec%0d", v), tbl[v].gnt);
      clear_reqs();
      if (tbl[v].gnt >= 0) rsp_cycle($sformatf("vec%0d", v));
      check($sformatf("vec%0d lock", v), lock_valid_o, tbl[v].lock);
      if (tbl[v].lock) check($sformatf("vec%0d owner", v), lock_owner_o, tbl[v].owner);
    end

    // Owner TRIGGER releases the lock; a waiting PUSH then takes ownership.
    drive(1, 1'b1, R_PUSH, 64'hA5, 8'hFF);
    step_check("ho push1", 1);
    clear_reqs();
    rsp_cycle("ho push1");
    check("ho owner1", {lock_valid_o, lock_owner_o}, {1'b1, 2'd1});
    drive(0, 1'b1, R_PUSH, 64'h1234, 8'h0F);
    drive(1, 1'b1, R_TRIG, 64'h1, 8'hFF);
    step_check("ho trig", 1);
    req_q_valid_i[1] = 1'b0;
    #3;
    check("ho lock cleared", lock_valid_o, 0);
    check("ho wait q_ready", req_q_ready_o, 0);
    @(posedge clk); #1;
    step_check("ho push0", 0);
    clear_reqs();
    rsp_cycle("ho push0");
    check("ho owner0", {lock_valid_o, lock_owner_o}, {1'b1, 2'd0});

    // Owner withholds p_ready: response held stable, nothing else forwarded.
    req_p_ready_i[0] = 1'b0;
    drive(0, 1'b0, R_STAT, 64'h0, 8'h00);
    step_check("bp status", 0);
    clear_reqs();
    drive(2, 1'b0, R_JOB, 64'h0, 8'h00);
    expv = '0;
    expv[0] = 64'h1;
    for (int c = 0; c < 5; c++) begin
      #3;
      check($sformatf("bp%0d p_valid", c), req_p_valid_o, 4'b0001);
      check($sformatf("bp%0d p_data", c), req_p_data_o, expv);
      check($sformatf("bp%0d tgt_q_valid", c), tgt_q_valid_o, 0);
      check($sformatf("bp%0d q_ready", c), req_q_ready_o, 0);
      @(posedge clk); #1;
    end
    req_p_ready_i[0] = 1'b1;
    #3;
    check("bp release p_valid", req_p_valid_o, 4'b0001);
    check("bp release tgt_p_ready", tgt_p_ready_o, 1);
    @(posedge clk); #1;
    step_check("bp resume", 2);
    clear_reqs();
    rsp_cycle("bp resume");

    // Reset while a response is outstanding and the lock is held.
    req_p_ready_i[0] = 1'b0;
    drive(0, 1'b1, R_PULL, 64'hFEED, 8'hFF);
    step_check("rst_mid pull", 0);
    clear_reqs();
    #3;
    check("rst_mid pending", req_p_valid_o, 4'b0001);
    check("rst_mid locked", lock_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid p_valid", req_p_valid_o, 0);
    check("rst_mid p_data", req_p_data_o, 0);
    check("rst_mid tgt_p_ready", tgt_p_ready_o, 1);
    check("rst_mid tgt_q_valid", tgt_q_valid_o, 0);
    check("rst_mid q_ready", req_q_ready_o, 0);
    check("rst_mid lock", {lock_valid_o, lock_owner_o}, 0);
    check("rst_mid lost rsp", sb.size(), 1);
    sb.delete();
    rr_exp = 0;
    req_p_ready_i = '1;
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) drive(i, 1'b0, R_JOB, 64'(i), 8'hFF);
    step_check("post_rst rr", rr_exp);
    clear_reqs();
    rsp_cycle("post_rst rr");

    check("scoreboard empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
